motor_ramp_limiter: RTL
=======================

MOTOR_RAMP_LIMITER -- requirements
Module: motor_ramp_limiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 32: clk cycles per ramp tick, legal range 2..255.
REQ-002 SHALL have parameter STEP_UP, default 4: duty increment per tick.
REQ-003 SHALL have parameter STEP_DOWN, default 8: duty decrement per tick.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst_n, input, 1: reset; asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: system power-enabled.
REQ-007 SHALL have port thermal_fault, input, 1: overtemperature flag.
REQ-008 SHALL have port target_speed, input, 8: requested motor speed, unsigned.
REQ-009 SHALL have port target_valid, input, 1: target_speed is valid.
REQ-010 SHALL have port target_ready, output, 1: block accepts a target.
REQ-011 SHALL have port duty_out, output, 8: slew-limited duty for the PWM stage.
REQ-012 SHALL have port duty_valid, output, 1: duty_out holds a new update.
REQ-013 SHALL have port duty_ready, input, 1: PWM stage accepts the update.
REQ-014 SHALL have port state_out, output, 3: current FSM state encoding.
REQ-015 SHALL have port at_target, output, 1: duty_out equals the effective target.

Function
REQ-016 SHALL capture target_speed into tgt_q on a cycle where target_valid && target_ready; target_ready SHALL equal enable.
REQ-017 SHALL run a tick counter 0..TICK_DIV-1 while enable=1, wrapping to 0; tick SHALL pulse on the count TICK_DIV-1; the counter SHALL be held at 0 while enable=0.
REQ-018 SHALL define eff_tgt = tgt_q, except as specified in REQ-031.
REQ-019 SHALL implement states OFF=0, IDLE=1, RAMP_UP=2, RAMP_DOWN=3, DERATE=4.
REQ-020 SHALL transition OFF->IDLE on the first cycle with enable=1.
REQ-021 SHALL transition from any state to OFF when enable=0; in that same clock edge duty_out SHALL become 0, duty_valid SHALL become 1, and tgt_q SHALL become 0.
REQ-022 SHALL, in IDLE/RAMP_UP/RAMP_DOWN on each tick, select RAMP_UP if duty_out<eff_tgt, RAMP_DOWN if duty_out>eff_tgt, else IDLE.
REQ-023 SHALL, in RAMP_UP on a tick, set duty_out = min(duty_out+STEP_UP, eff_tgt), computed 9-bit so there is no 8-bit wrap.
REQ-024 SHALL, in RAMP_DOWN on a tick, set duty_out = max(duty_out-STEP_DOWN, eff_tgt), with no underflow below eff_tgt or 0.
REQ-025 SHALL set duty_valid=1 on the edge where duty_out changes, and hold duty_out and duty_valid stable until duty_ready=1.
REQ-026 SHALL skip a tick's step while duty_valid=1 && duty_ready=0 (stall); the tick counter SHALL continue counting.
REQ-027 SHALL, when a target handshake and a tick coincide, step using the old tgt_q; the new target SHALL take effect from the next tick.
REQ-028 SHALL drive at_target = (duty_out==eff_tgt) combinationally.
REQ-029 SHALL write tgt_q only through the handshake; a new target mid-ramp SHALL reverse direction at the next tick without overshoot.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously clear duty_out=0, duty_valid=0, tgt_q=0, tick counter=0, state=OFF; target_ready follows enable.

Configuration
REQ-031 SHALL, with MOTOR_RAMP_DERATE_EN defined, use eff_tgt = tgt_q>>1 while thermal_fault=1 and show state DERATE (ramp down at STEP_DOWN and hold at the cap), returning to IDLE/RAMP_* on the first tick after thermal_fault falls.
REQ-032 SHALL, without MOTOR_RAMP_DERATE_EN, ignore thermal_fault; DERATE SHALL be unreachable.

Structure
REQ-033 SHALL place the state encoding enum and the derate shift constant in shared package ev_ctrl_pkg.
REQ-034 SHALL place the tick counter in sub-module ramp_tick_gen (ports clk, rst_n, run, tick).

Verification (TICK_DIV=4, STEP_UP=4, STEP_DOWN=8, duty_ready=1 unless stated)
REQ-035 SHALL cover: enable=1, target 20 -> duty 4,8,12,16,20 on successive ticks (every 4 clk), then IDLE and at_target=1.
REQ-036 SHALL cover: from duty 20, target 3 -> duty 12, 4, 3 (clamped), state RAMP_DOWN then IDLE.
REQ-037 SHALL cover: target 255 from 252 -> duty 255 in one tick with no wrap; then target 0 from 7 -> 0 with no underflow.
REQ-038 SHALL cover: duty_ready=0 for 3 ticks mid-ramp -> duty_out is frozen with duty_valid=1, and ramping resumes one step per tick after release.
REQ-039 SHALL cover: enable dropping at duty 100 -> next edge gives duty_out=0, state OFF, duty_valid=1; asserting rst_n mid-ramp clears all state asynchronously.
REQ-040 SHALL cover, with DERATE_EN, target 200 held at duty 200 and thermal_fault=1 -> state DERATE, duty steps down by 8 per tick to 100 and holds; without the macro, duty stays at 200.

Source files
------------

// File: rtl/ev_ctrl_pkg.sv
// Shared definitions for the EV motor control slice: FSM state encoding,
// the thermal derate shift and a helper that applies it.
package ev_ctrl_pkg;

    // Ramp limiter FSM state encoding (3-bit, exported on state_out)
    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_RAMP_UP   = 3'd2;
    localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
    localparam logic [2:0] ST_DERATE    = 3'd4;

    // Thermal derate caps the target at tgt >> DERATE_SHIFT (half speed)
    localparam int unsigned DERATE_SHIFT = 32'd1;

    function automatic logic [7:0] derate_cap(input logic [7:0] tgt);
        return tgt >> DERATE_SHIFT;
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp tick generator: counts 0..TICK_DIV-1 while run is high and pulses
// tick on the terminal count; the count is parked at 0 while run is low.
module ramp_tick_gen #(
    parameter int TICK_DIV = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);

    localparam logic [7:0] LAST_CNT = 8'(TICK_DIV - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: wrap at the terminal value, hold at zero when not running
    always_comb begin
        count_d = count_q;
        if (!run) begin
            count_d = 8'd0;
        end else if (count_q == LAST_CNT) begin
            count_d = 8'd0;
        end else begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = run && (count_q == LAST_CNT);

endmodule

// File: rtl/motor_ramp_limiter.sv
// Motor duty slew-rate limiter. Accepts a target speed through a
// valid/ready handshake and moves duty_out toward it by at most STEP_UP /
// STEP_DOWN per ramp tick, publishing each change through duty_valid/ready.
// Optional thermal derate (halved target, DERATE state) is built when the
// macro MOTOR_RAMP_DERATE_EN is defined.
module motor_ramp_limiter
    import ev_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 32,
    parameter int STEP_UP   = 4,
    parameter int STEP_DOWN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       thermal_fault,
    input  logic [7:0] target_speed,
    input  logic       target_valid,
    output logic       target_ready,
    output logic [7:0] duty_out,
    output logic       duty_valid,
    input  logic       duty_ready,
    output logic [2:0] state_out,
    output logic       at_target
);

    localparam logic [8:0] UP9 = 9'(STEP_UP);
    localparam logic [8:0] DN9 = 9'(STEP_DOWN);

    logic [2:0] state_q, state_d;
    logic [7:0] duty_q, duty_d;
    logic       duty_valid_q, duty_valid_d;
    logic [7:0] tgt_q, tgt_d;
    logic [7:0] eff_tgt_s;
    logic       derating_s;
    logic       tick_s;
    logic       stall_s;
    logic [8:0] up_sum_s;
    logic [8:0] dn_gap_s;
    logic [7:0] up_duty_s;
    logic [7:0] dn_duty_s;

    ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (enable),
        .tick  (tick_s)
    );

`ifdef MOTOR_RAMP_DERATE_EN
    assign derating_s = thermal_fault;
    assign eff_tgt_s  = thermal_fault ? derate_cap(tgt_q) : tgt_q;
`else
    logic thermal_fault_unused_s;
    assign thermal_fault_unused_s = thermal_fault;
    assign derating_s = 1'b0;
    assign eff_tgt_s  = tgt_q;
`endif

    assign target_ready = enable;
    assign stall_s      = duty_valid_q && !duty_ready;

    // Candidate step values, computed 9-bit so neither direction can wrap
    always_comb begin
        up_sum_s  = {1'b0, duty_q} + UP9;
        dn_gap_s  = {1'b0, duty_q} - {1'b0, eff_tgt_s};
        up_duty_s = (up_sum_s >= {1'b0, eff_tgt_s}) ? eff_tgt_s : up_sum_s[7:0];
        dn_duty_s = (dn_gap_s <= DN9) ? eff_tgt_s : (duty_q - DN9[7:0]);
    end

    // FSM, target capture and duty update
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        duty_valid_d = duty_valid_q;
        tgt_d        = tgt_q;
        if (duty_valid_q && duty_ready) begin
            duty_valid_d = 1'b0;
        end else begin
            duty_valid_d = duty_valid_q;
        end
        if (target_valid && target_ready) begin
            tgt_d = target_speed;
        end else begin
            tgt_d = tgt_q;
        end
        if (!enable) begin
            // Power removed: force the output off regardless of the handshake
            state_d = ST_OFF;
            tgt_d   = 8'd0;
            if (state_q != ST_OFF) begin
                duty_d       = 8'd0;
                duty_valid_d = 1'b1;
            end else begin
                duty_d = duty_q;
            end
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_IDLE;
                end
`ifdef MOTOR_RAMP_DERATE_EN
                ST_IDLE, ST_RAMP_UP, ST_RAMP_DOWN, ST_DERATE: begin
`else
                ST_IDLE, ST_RAMP_UP, ST_RAMP_DOWN: begin
`endif
                    // Entering derate is immediate; leaving waits for a tick
                    if (derating_s) begin
                        state_d = ST_DERATE;
                    end else begin
                        state_d = state_q;
                    end
                    if (tick_s && !stall_s) begin
                        if (duty_q < eff_tgt_s) begin
                            state_d      = derating_s ? ST_DERATE : ST_RAMP_UP;
                            duty_d       = up_duty_s;
                            duty_valid_d = 1'b1;
                        end else if (duty_q > eff_tgt_s) begin
                            state_d      = derating_s ? ST_DERATE : ST_RAMP_DOWN;
                            duty_d       = dn_duty_s;
                            duty_valid_d = 1'b1;
                        end else begin
                            state_d = derating_s ? ST_DERATE : ST_IDLE;
                        end
                    end else begin
                        duty_d = duty_q;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            duty_q       <= 8'd0;
            duty_valid_q <= 1'b0;
            tgt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            duty_q       <= duty_d;
            duty_valid_q <= duty_valid_d;
            tgt_q        <= tgt_d;
        end
    end

    assign duty_out   = duty_q;
    assign duty_valid = duty_valid_q;
    assign state_out  = state_q;
    assign at_target  = (duty_q == eff_tgt_s);

endmodule
